// File: rtl/id_forward_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : id_forward_ctrl
// Brief    : Decode-stage forwarding selects and load-use stall control,
//            backed by a two-slot EX/MEM scoreboard of pending writes.
// Revision : 1.0 - initial release
// ============================================================================
module id_forward_ctrl #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [31:0]            Instr1_IN,
    input  logic                   reg_write,
    input  logic                   link_out,
    input  logic                   branch_out,
    input  logic                   jump_out,
    input  logic                   jump_reg_out,
    input  logic                   use_rd,
    input  logic                   store_fu,
    input  logic                   mem_read_id,
    input  logic                   sys_flush,
    output logic [1:0]             Branch_JR_select_A_FU,
    output logic [1:0]             Branch_JR_select_B_FU,
    output logic                   Fwd_Stall,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam logic [0:0] c_ST_RUN   = 1'b0;
    localparam logic [0:0] c_ST_STALL = 1'b1;

    localparam logic [1:0] c_SEL_RF  = 2'd0;
    localparam logic [1:0] c_SEL_ALU = 2'd1;
    localparam logic [1:0] c_SEL_MEM = 2'd2;

    localparam logic [4:0] c_REG_LINK = 5'd31;

    logic                   r_ex_valid;
    logic [4:0]             r_ex_dest;
    logic                   r_ex_load;
    logic                   r_mem_valid;
    logic [4:0]             r_mem_dest;
    logic [0:0]             r_state;
    logic [0:0]             w_state_nxt;
    logic [STALL_CNT_W-1:0] r_stall_count;

    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic [4:0] w_rd;
    logic [4:0] w_id_dest;
    logic       w_id_valid;
    logic       w_rs_needed;
    logic       w_rt_needed;
    logic       w_rs_hazard;
    logic       w_rt_hazard;
    logic       w_hazard;
    logic       w_unused_bits;

    assign w_rs = Instr1_IN[25:21];
    assign w_rt = Instr1_IN[20:16];
    assign w_rd = Instr1_IN[15:11];

    // Opcode/funct/immediate bits and the JR flag carry no extra information here:
    // JR reads rs, which is already treated as needed by default.
    assign w_unused_bits = ^{Instr1_IN[31:26], Instr1_IN[10:0], jump_reg_out};

    assign w_id_dest   = use_rd ? w_rd : (link_out ? c_REG_LINK : w_rt);
    assign w_id_valid  = reg_write && (w_id_dest != 5'd0);

    assign w_rs_needed = !(link_out && jump_out);
    assign w_rt_needed = use_rd || branch_out || store_fu;

    function automatic logic [1:0] f_sel(
        input logic [4:0] src,
        input logic       needed,
        input logic       ex_valid,
        input logic [4:0] ex_dest,
        input logic       ex_load,
        input logic       mem_valid,
        input logic [4:0] mem_dest
    );
        logic [1:0] sel;
        sel = c_SEL_RF;
        if (needed && (src != 5'd0)) begin
            if (ex_valid && (ex_dest == src) && !ex_load) begin
                sel = c_SEL_ALU;
            end else if (mem_valid && (mem_dest == src)) begin
                sel = c_SEL_MEM;
            end
        end
        return sel;
    endfunction

    assign Branch_JR_select_A_FU = f_sel(w_rs, w_rs_needed, r_ex_valid, r_ex_dest,
                                         r_ex_load, r_mem_valid, r_mem_dest);
    assign Branch_JR_select_B_FU = f_sel(w_rt, w_rt_needed, r_ex_valid, r_ex_dest,
                                         r_ex_load, r_mem_valid, r_mem_dest);

    // Slot dest is never r0 while valid, so r0 sources cannot hazard.
    assign w_rs_hazard = w_rs_needed && r_ex_valid && r_ex_load && (r_ex_dest == w_rs);
    assign w_rt_hazard = w_rt_needed && r_ex_valid && r_ex_load && (r_ex_dest == w_rt);
    assign w_hazard    = w_rs_hazard || w_rt_hazard;

    // Only one stall cycle is ever needed: by then the load sits in MEM.
    always_comb begin
        w_state_nxt = r_state;
        Fwd_Stall   = 1'b0;
        case (r_state)
            c_ST_RUN: begin
                if (w_hazard) begin
                    Fwd_Stall   = 1'b1;
                    w_state_nxt = c_ST_STALL;
                end
            end
            c_ST_STALL: begin
                w_state_nxt = c_ST_RUN;
            end
            default: begin
                w_state_nxt = c_ST_RUN;
            end
        endcase
        if (sys_flush) begin
            w_state_nxt = c_ST_RUN;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= c_ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET || sys_flush) begin
            r_ex_valid  <= 1'b0;
            r_ex_dest   <= 5'd0;
            r_ex_load   <= 1'b0;
            r_mem_valid <= 1'b0;
            r_mem_dest  <= 5'd0;
        end else begin
            r_mem_valid <= r_ex_valid;
            r_mem_dest  <= r_ex_dest;
            if (Fwd_Stall) begin
                r_ex_valid <= 1'b0;
                r_ex_dest  <= 5'd0;
                r_ex_load  <= 1'b0;
            end else begin
                r_ex_valid <= w_id_valid;
                r_ex_dest  <= w_id_valid ? w_id_dest : 5'd0;
                r_ex_load  <= w_id_valid && mem_read_id;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_stall_count <= '0;
        end else if (Fwd_Stall && (r_stall_count != {STALL_CNT_W{1'b1}})) begin
            r_stall_count <= r_stall_count + STALL_CNT_W'(1);
        end
    end

    assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_id_forward_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_forward_ctrl
// Brief    : Directed-vector scoreboard bench for id_forward_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_forward_ctrl;

    // Narrow counter so saturation is reachable in a handful of stalls.
    localparam int c_CNT_W = 3;

    localparam logic [8:0] c_F_RW  = 9'h080;
    localparam logic [8:0] c_F_LNK = 9'h040;
    localparam logic [8:0] c_F_BR  = 9'h020;
    localparam logic [8:0] c_F_J   = 9'h010;
    localparam logic [8:0] c_F_JR  = 9'h008;
    localparam logic [8:0] c_F_RD  = 9'h004;
    localparam logic [8:0] c_F_ST  = 9'h002;
    localparam logic [8:0] c_F_LD  = 9'h001;
    localparam logic [8:0] c_F_FL  = 9'h100;

    localparam logic [8:0] c_ALU  = c_F_RW | c_F_RD;
    localparam logic [8:0] c_LW   = c_F_RW | c_F_LD;
    localparam logic [8:0] c_JAL  = c_F_RW | c_F_LNK | c_F_J;

    typedef struct {
        string       name;
        logic [1:0]  sel_a;
        logic [1:0]  sel_b;
        logic        stall;
        int unsigned cnt;
    } exp_t;

    logic                CLK;
    logic                RESET;
    logic [31:0]         Instr1_IN;
    logic                reg_write, link_out, branch_out, jump_out, jump_reg_out;
    logic                use_rd, store_fu, mem_read_id, sys_flush;
    logic [1:0]          Branch_JR_select_A_FU;
    logic [1:0]          Branch_JR_select_B_FU;
    logic                Fwd_Stall;
    logic [c_CNT_W-1:0]  stall_count;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    id_forward_ctrl #(.STALL_CNT_W(c_CNT_W)) dut (
        .CLK                  (CLK),
        .RESET                (RESET),
        .Instr1_IN            (Instr1_IN),
        .reg_write            (reg_write),
        .link_out             (link_out),
        .branch_out           (branch_out),
        .jump_out             (jump_out),
        .jump_reg_out         (jump_reg_out),
        .use_rd               (use_rd),
        .store_fu             (store_fu),
        .mem_read_id          (mem_read_id),
        .sys_flush            (sys_flush),
        .Branch_JR_select_A_FU(Branch_JR_select_A_FU),
        .Branch_JR_select_B_FU(Branch_JR_select_B_FU),
        .Fwd_Stall            (Fwd_Stall),
        .stall_count          (stall_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] f_rtype(input logic [4:0] rs, input logic [4:0] rt,
                                            input logic [4:0] rd);
        return {6'd0, rs, rt, rd, 11'd0};
    endfunction

    function automatic logic [31:0] f_itype(input logic [5:0] op, input logic [4:0] rs,
                                            input logic [4:0] rt);
        return {op, rs, rt, 16'd0};
    endfunction

    // Drive one ID cycle, queue its expected response, advance to the next cycle.
    task automatic step(input string name, input logic [31:0] ins, input logic [8:0] f,
                        input logic [1:0] ea, input logic [1:0] eb, input logic es,
                        input int unsigned ec);
        exp_t e;
        Instr1_IN    = ins;
        reg_write    = f[7];
        link_out     = f[6];
        branch_out   = f[5];
        jump_out     = f[4];
        jump_reg_out = f[3];
        use_rd       = f[2];
        store_fu     = f[1];
        mem_read_id  = f[0];
        sys_flush    = f[8];
        e.name  = name;
        e.sel_a = ea;
        e.sel_b = eb;
        e.stall = es;
        e.cnt   = ec;
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    task automatic cmp(input string name, input int unsigned act, input int unsigned req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: outputs are valid every cycle; compare mid-cycle against the queue head.
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp({e.name, ".selA"},  32'(Branch_JR_select_A_FU), 32'(e.sel_a));
            cmp({e.name, ".selB"},  32'(Branch_JR_select_B_FU), 32'(e.sel_b));
            cmp({e.name, ".stall"}, 32'(Fwd_Stall),             32'(e.stall));
            cmp({e.name, ".cnt"},   32'(stall_count),           e.cnt);
        end
    end

    initial begin
        int unsigned cnt;
        int          guard;
        RESET = 1'b1;
        Instr1_IN = '0;
        {reg_write, link_out, branch_out, jump_out, jump_reg_out} = '0;
        {use_rd, store_fu, mem_read_id, sys_flush} = '0;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;

        step("reset",     32'd0,                  9'h000, 2'd0, 2'd0, 1'b0, 0);
        step("add_r3",    f_rtype(1, 2, 3),       c_ALU,  2'd0, 2'd0, 1'b0, 0);
        step("sub_ex",    f_rtype(3, 4, 5),       c_ALU,  2'd1, 2'd0, 1'b0, 0);
        step("nop0",      32'd0,                  9'h000, 2'd0, 2'd0, 1'b0, 0);
        step("add_r3b",   f_rtype(1, 2, 3),       c_ALU,  2'd0, 2'd0, 1'b0, 0);
        step("nop1",      32'd0,                  9'h000, 2'd0, 2'd0, 1'b0, 0);
        step("beq_mem",   f_itype(6'h04, 3, 3),   c_F_BR, 2'd2, 2'd2, 1'b0, 0);

        step("lw_r4",     f_itype(6'h23, 1, 4),   c_LW,   2'd0, 2'd0, 1'b0, 0);
        step("use_stall", f_rtype(4, 4, 6),       c_ALU,  2'd0, 2'd0, 1'b1, 0);
        step("use_fwd",   f_rtype(4, 4, 6),       c_ALU,  2'd2, 2'd2, 1'b0, 1);

        step("addi_r0",   f_itype(6'h08, 1, 0),   c_F_RW, 2'd0, 2'd0, 1'b0, 1);
        step("add_r0src", f_rtype(0, 0, 2),       c_ALU,  2'd0, 2'd0, 1'b0, 1);
        step("jal",       {6'h03, 26'd0},         c_JAL,  2'd0, 2'd0, 1'b0, 1);
        step("jr_r31",    f_rtype(31, 0, 0),      c_F_JR, 2'd1, 2'd0, 1'b0, 1);

        step("lw_r7",     f_itype(6'h23, 1, 7),   c_LW,   2'd0, 2'd0, 1'b0, 1);
        step("flush_haz", f_rtype(7, 7, 8),       c_ALU | c_F_FL, 2'd0, 2'd0, 1'b1, 1);
        step("post_flush",f_rtype(7, 7, 8),       c_ALU,  2'd0, 2'd0, 1'b0, 2);

        step("add_r8",    f_rtype(1, 2, 8),       c_ALU,  2'd0, 2'd0, 1'b0, 2);
        step("ex_over",   f_rtype(8, 8, 9),       c_ALU,  2'd1, 2'd1, 1'b0, 2);
        step("sw",        f_itype(6'h2b, 8, 9),   c_F_ST, 2'd2, 2'd1, 1'b0, 2);

        cnt = 2;
        for (int k = 0; k < 6; k++) begin
            step("sat_lw",    f_itype(6'h23, 1, 4), c_LW,  2'd0, 2'd0, 1'b0, cnt);
            step("sat_stall", f_rtype(4, 4, 6),     c_ALU, 2'd0, 2'd0, 1'b1, cnt);
            if (cnt < 7) cnt++;
            step("sat_fwd",   f_rtype(4, 4, 6),     c_ALU, 2'd2, 2'd2, 1'b0, cnt);
        end

        step("rst_lw",    f_itype(6'h23, 1, 4),   c_LW,   2'd0, 2'd0, 1'b0, 7);
        step("rst_stall", f_rtype(4, 4, 6),       c_ALU,  2'd0, 2'd0, 1'b1, 7);
        RESET = 1'b1;
        step("rst_mid",   f_rtype(4, 4, 6),       c_ALU,  2'd2, 2'd2, 1'b0, 7);
        RESET = 1'b0;
        step("post_rst",  f_rtype(4, 4, 6),       c_ALU,  2'd0, 2'd0, 1'b0, 0);
        step("run_lw",    f_itype(6'h23, 1, 4),   c_LW,   2'd0, 2'd0, 1'b0, 0);
        step("run_stall", f_rtype(4, 4, 6),       c_ALU,  2'd0, 2'd0, 1'b1, 0);
        step("run_fwd",   f_rtype(4, 4, 6),       c_ALU,  2'd2, 2'd2, 1'b0, 1);

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge CLK);
            guard++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
